// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: synchronizes and debounces a raw push-button, then emits a
// registered one-cycle strobe per accepted press along with the debounced
// level and the current FSM state.
//
// A new button value is accepted only after DEBOUNCE_CYCLES+1 consecutive
// synchronized samples agree: the first sample moves IDLE->ARMING (or
// HELD->RELEASING), and the remaining DEBOUNCE_CYCLES samples run cnt from 0
// up to DEBOUNCE_CYCLES-1.
//
// Optional feature macro: BTN_AUTOREPEAT_EN. When it is defined, a held
// button also produces auto-repeat pulses: the first one REPEAT_DELAY cycles
// after the press pulse, then one every REPEAT_PERIOD cycles.
module btn_pulse_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    output logic       pulse,
    output logic       level,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        HELD      = 2'b10,
        RELEASING = 2'b11
    } state_t;

    localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

    // Power-up values match the reset values.
    logic        sync1   = 1'b0;
    logic        btn_s   = 1'b0;
    state_t      state_q = IDLE;
    state_t      state_d;
    logic [15:0] cnt_q   = 16'd0;
    logic [15:0] cnt_d;
    logic        pulse_q = 1'b0;
    logic        level_q = 1'b0;
    logic        press_pulse;
    logic        rpt_pulse;

    // Two-flop synchronizer; btn_s is the only signal the FSM looks at.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            sync1 <= btn_in;
            btn_s <= sync1;
        end
    end

    // State, debounce counter and registered outputs; reset wins over
    // every transition, including the one that would raise pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            pulse_q <= 1'b0;
            level_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= press_pulse | rpt_pulse;
            level_q <= (state_d == HELD) || (state_d == RELEASING);
        end
    end

    // Next-state logic: cnt is reloaded on every state change and stops at
    // CNT_MAX because reaching it always forces a transition.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        press_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = ARMING;
                    cnt_d   = 16'd0;
                end
            end
            ARMING: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = HELD;
                    cnt_d       = 16'd0;
                    press_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASING;
                    cnt_d   = 16'd0;
                end
            end
            RELEASING: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = 16'd0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [15:0] RPT_DELAY_MAX  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPT_PERIOD_MAX = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rpt_q     = 16'd0;
    logic [15:0] rpt_d;
    logic        rpt_phase_q = 1'b0;  // 0: waiting for first repeat, 1: periodic
    logic        rpt_phase_d;

    // Repeat counter: restarts on the press, counts while HELD with the button
    // down, freezes through RELEASING and clears once the press is abandoned.
    always_comb begin
        rpt_d       = rpt_q;
        rpt_phase_d = rpt_phase_q;
        rpt_pulse   = 1'b0;
        if (state_q == ARMING && state_d == HELD) begin
            rpt_d       = 16'd0;
            rpt_phase_d = 1'b0;
        end else if (state_q == HELD && state_d == HELD) begin
            if (rpt_q == (rpt_phase_q ? RPT_PERIOD_MAX : RPT_DELAY_MAX)) begin
                rpt_pulse   = 1'b1;
                rpt_d       = 16'd0;
                rpt_phase_d = 1'b1;
            end else begin
                rpt_d = rpt_q + 16'd1;
            end
        end else if (state_d == IDLE || state_d == ARMING) begin
            rpt_d       = 16'd0;
            rpt_phase_d = 1'b0;
        end
    end

    // Repeat counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_q       <= 16'd0;
            rpt_phase_q <= 1'b0;
        end else begin
            rpt_q       <= rpt_d;
            rpt_phase_q <= rpt_phase_d;
        end
    end
`else
    // No repeat logic: legal repeat parameters are >= 1, so this folds to 0.
    assign rpt_pulse = (REPEAT_DELAY == 0) && (REPEAT_PERIOD == 0);
`endif

    assign pulse = pulse_q;
    assign level = level_q;
    assign state = state_q;

endmodule
